mem_access_ctrl: RTL
====================

# mem_access_ctrl

Sequencing controller between the CPU load/store unit and the 256x32 word-wide data RAM. Accepts one byte, half-word, word or double-word access at a time over a Req/Ready handshake. Breaks each access into single-word RAM cycles: lane extraction with optional sign extension for loads, read-modify-write for sub-word stores, and two word cycles for double-words. Detects misaligned or out-of-range addresses before any RAM cycle is issued.

## Interface
- No parameters; RAM depth is fixed at 256 words and data width at 32 bits.
- Clk  in  1  single clock; all state changes on the rising edge
- Reset  in  1  synchronous, active-high
- Req  in  1  access request; sampled only in IDLE
- ReadWrite  in  1  0 = load (read), 1 = store (write)
- DataSize  in  2  00 byte, 01 half-word, 10 word, 11 double-word
- SignExt  in  1  loads only: 1 = sign-extend byte/half-word, 0 = zero-extend
- Address  in  32  byte address
- DataIn  in  32  store data; low byte/half-word used for sub-word stores; first word of a double-word
- DataIn2  in  32  second (upper-address) word of a double-word store
- DataOut  out  32  load result; first word of a double-word
- DataOut2  out  32  second word of a double-word load
- Ready  out  1  one-cycle completion pulse
- Busy  out  1  access in progress
- Err  out  1  valid with Ready: access rejected, no RAM cycle issued
- MemEnable  out  1  RAM cycle strobe
- MemReadWrite  out  1  RAM direction, 0 = read, 1 = write
- MemAddress  out  8  RAM word index
- MemDataIn  out  32  RAM write data
- MemDataOut  in  32  RAM read data, valid the cycle after a read strobe

## Operation
- Addressing:
  - word index = Address[9:2]
  - byte lane = Address[1:0], little-endian: lane 0 = bits 7:0
  - half-word lane = Address[1]
- Err conditions:
  - Address[31:10] != 0
  - half-word with Address[0] = 1
  - word or double-word with Address[1:0] != 00
- Inputs are latched on acceptance; later input changes have no effect until the next acceptance.
- States: IDLE, RD_A, CAP_A, WR_A, RD_B, CAP_B, WR_B, DONE.
- IDLE: on Req = 1, latch inputs.
  - Err condition -> DONE with Err = 1.
  - Load, or byte/half-word store -> RD_A.
  - Word or double-word store -> WR_A.
- RD_A: MemEnable = 1, MemReadWrite = 0, MemAddress = index. Next state CAP_A.
- CAP_A: capture MemDataOut.
  - Load: extract the lane, extend it, register into DataOut.
  - Sub-word store: merge DataIn[7:0] or DataIn[15:0] into the selected lane; other lanes keep the RAM value.
  - Next state: double-word load -> RD_B; load -> DONE; store -> WR_A.
- WR_A: MemEnable = 1, MemReadWrite = 1, MemAddress = index, MemDataIn = merged word or DataIn. Next state WR_B if double-word, else DONE.
- RD_B / CAP_B / WR_B: same behaviour as the A states at index+1 mod 256 (255 wraps to 0). CAP_B loads DataOut2.
- DONE: Ready = 1 for exactly one cycle. Next state IDLE.
- Busy = 1 in every state except IDLE.
- MemEnable = 0 in IDLE, CAP_A, CAP_B and DONE.
- DataOut/DataOut2 are updated only by loads and hold between accesses. Stores and errored accesses leave them unchanged.

## Timing
- Reset values: state IDLE, Ready 0, Busy 0, Err 0, MemEnable 0, MemReadWrite 0, MemAddress 0, MemDataIn 0, DataOut 0, DataOut2 0.
- Cycle N is the Req = 1 cycle in IDLE. Ready is asserted in cycle:
  - N+3: byte, half-word or word load
  - N+5: double-word load
  - N+2: word store
  - N+3: double-word store
  - N+4: byte or half-word store
  - N+1: Err
- Req is ignored while Busy = 1 and during DONE. The next acceptance is earliest the cycle after DONE.
- Reset asserted mid-access returns to IDLE on the next edge, with all outputs at reset values.
  - A completed WR_A of a double-word stays in RAM.
  - No Ready pulse is produced for the aborted access.
- Err is cleared when the next request is accepted.

## Test plan
- Word store 0xDEADBEEF at Address 0x10, then word load at 0x10: RAM word 4 written in N+1; Ready at N+2; load returns DataOut = 0xDEADBEEF, Ready at N+3.
- RAM word 4 = 0x11223344:
  - byte load, Address 0x12, SignExt = 0 -> DataOut = 0x00000022
  - half-word load, Address 0x12, SignExt = 1, with word 4 = 0x80FF0000 -> DataOut = 0xFFFF80FF
- RAM word 4 = 0x11223344, byte store DataIn = 0xAB at 0x11 -> RAM word 4 = 0x1122AB44, Ready at N+4, DataOut unchanged.
- Double-word store DataIn = 0xA, DataIn2 = 0xB at Address 0x3FC -> words 255 and 0 written. Double-word load at 0x3FC -> DataOut = 0xA, DataOut2 = 0xB, Ready at N+5.
- Errors:
  - half-word at 0x13 -> Err = 1 and Ready at N+1, MemEnable never asserted
  - Address 0x400 -> same Err response
  - Req pulses while Busy -> no extra accesses
- Reset asserted during RD_B of a double-word load -> IDLE next cycle, DataOut = 0, Busy = 0, Ready never pulses.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one CPU load/store at a time onto a 256x32
// word-wide RAM. Sub-word loads are lane-extracted and optionally
// sign-extended. Sub-word stores use read-modify-write. Double-words take
// two consecutive word cycles, and the second word index wraps at 255.
// Misaligned or out-of-range addresses are rejected before any RAM cycle.
module mem_access_ctrl (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Req,
   input  logic        ReadWrite,
   input  logic [1:0]  DataSize,
   input  logic        SignExt,
   input  logic [31:0] Address,
   input  logic [31:0] DataIn,
   input  logic [31:0] DataIn2,
   output logic [31:0] DataOut,
   output logic [31:0] DataOut2,
   output logic        Ready,
   output logic        Busy,
   output logic        Err,
   output logic        MemEnable,
   output logic        MemReadWrite,
   output logic [7:0]  MemAddress,
   output logic [31:0] MemDataIn,
   input  logic [31:0] MemDataOut
);

   typedef enum logic [2:0] {
      IDLE, RD_A, CAP_A, WR_A, RD_B, CAP_B, WR_B, DONE
   } state_e;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'b00,
      SZ_HALF  = 2'b01,
      SZ_WORD  = 2'b10,
      SZ_DWORD = 2'b11
   } size_e;

   // Pick the addressed byte or half-word out of a RAM word and extend it.
   // Word and double-word accesses pass the whole word through.
   function automatic logic [31:0] extract_lane(input logic [31:0] w,
                                                input size_e       sz,
                                                input logic [1:0]  lane,
                                                input logic        sx);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = w[{lane, 3'b000} +: 8];
      h = lane[1] ? w[31:16] : w[15:0];
      case (sz)
         SZ_BYTE: r = {{24{sx & b[7]}}, b};
         SZ_HALF: r = {{16{sx & h[15]}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

   // Overlay the low byte or half-word of the store data onto the selected
   // lane of the word read back from RAM. All other lanes keep the RAM value.
   function automatic logic [31:0] merge_lane(input logic [31:0] w,
                                              input logic [31:0] din,
                                              input size_e       sz,
                                              input logic [1:0]  lane);
      logic [31:0] r;
      r = w;
      case (sz)
         SZ_BYTE: r[{lane, 3'b000} +: 8] = din[7:0];
         SZ_HALF: r[{lane[1], 4'b0000} +: 16] = din[15:0];
         default: r = din;
      endcase
      return r;
   endfunction

   // Registered state and the access fields latched on acceptance.
   state_e      state_q,     state_d;
   logic        rw_q,        rw_d;
   size_e       size_q,      size_d;
   logic        sext_q,      sext_d;
   logic [7:0]  idx_q,       idx_d;
   logic [1:0]  lane_q,      lane_d;
   logic [31:0] din_q,       din_d;
   logic [31:0] din2_q,      din2_d;
   logic [31:0] merge_q,     merge_d;
   logic [31:0] data_out_q,  data_out_d;
   logic [31:0] data_out2_q, data_out2_d;
   logic        err_q,       err_d;

   logic        addr_err;
   logic [7:0]  idx_b;

   // Address is rejected if it is out of range or not aligned to the access size.
   always_comb begin
      addr_err = (|Address[31:10])
               | ((size_e'(DataSize) == SZ_HALF) & Address[0])
               | (DataSize[1] & (|Address[1:0]));
   end

   // The second word of a double-word uses the next index. The 8-bit sum wraps 255 to 0.
   assign idx_b = idx_q + 8'd1;

   // Compute next state and next values for all registers.
   // NOTE: every *_d gets a default first, so paths that leave a signal
   // unassigned still give a defined value and infer no latch.
   always_comb begin
      state_d     = state_q;
      rw_d        = rw_q;
      size_d      = size_q;
      sext_d      = sext_q;
      idx_d       = idx_q;
      lane_d      = lane_q;
      din_d       = din_q;
      din2_d      = din2_q;
      merge_d     = merge_q;
      data_out_d  = data_out_q;
      data_out2_d = data_out2_q;
      err_d       = err_q;

      case (state_q)
         IDLE: begin
            if (Req) begin
               rw_d   = ReadWrite;
               size_d = size_e'(DataSize);
               sext_d = SignExt;
               idx_d  = Address[9:2];
               lane_d = Address[1:0];
               din_d  = DataIn;
               din2_d = DataIn2;
               err_d  = addr_err;
               if (addr_err)
                  state_d = DONE;
               else if (!ReadWrite || !DataSize[1])
                  state_d = RD_A;
               else
                  state_d = WR_A;
            end
         end
         RD_A: state_d = CAP_A;
         CAP_A: begin
            if (!rw_q) begin
               data_out_d = extract_lane(MemDataOut, size_q, lane_q, sext_q);
               state_d    = (size_q == SZ_DWORD) ? RD_B : DONE;
            end else begin
               merge_d = merge_lane(MemDataOut, din_q, size_q, lane_q);
               state_d = WR_A;
            end
         end
         WR_A:  state_d = (size_q == SZ_DWORD) ? WR_B : DONE;
         RD_B:  state_d = CAP_B;
         CAP_B: begin
            data_out2_d = MemDataOut;
            state_d     = DONE;
         end
         WR_B:  state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Register update. Synchronous reset aborts any access in progress.
   // NOTE: non-blocking assignments here let every flop sample the values
   // from before the edge, whatever order the statements are written in.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= IDLE;
         rw_q        <= 1'b0;
         size_q      <= SZ_BYTE;
         sext_q      <= 1'b0;
         idx_q       <= 8'd0;
         lane_q      <= 2'd0;
         din_q       <= 32'd0;
         din2_q      <= 32'd0;
         merge_q     <= 32'd0;
         data_out_q  <= 32'd0;
         data_out2_q <= 32'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rw_q        <= rw_d;
         size_q      <= size_d;
         sext_q      <= sext_d;
         idx_q       <= idx_d;
         lane_q      <= lane_d;
         din_q       <= din_d;
         din2_q      <= din2_d;
         merge_q     <= merge_d;
         data_out_q  <= data_out_d;
         data_out2_q <= data_out2_d;
         err_q       <= err_d;
      end
   end

   // Handshake and RAM strobes are decoded from the state register alone.
   always_comb begin
      Busy         = (state_q != IDLE);
      Ready        = (state_q == DONE);
      Err          = err_q;
      DataOut      = data_out_q;
      DataOut2     = data_out2_q;
      MemEnable    = 1'b0;
      MemReadWrite = 1'b0;
      MemAddress   = 8'd0;
      MemDataIn    = 32'd0;
      case (state_q)
         RD_A: begin
            MemEnable  = 1'b1;
            MemAddress = idx_q;
         end
         WR_A: begin
            MemEnable    = 1'b1;
            MemReadWrite = 1'b1;
            MemAddress   = idx_q;
            MemDataIn    = size_q[1] ? din_q : merge_q;
         end
         RD_B: begin
            MemEnable  = 1'b1;
            MemAddress = idx_b;
         end
         WR_B: begin
            MemEnable    = 1'b1;
            MemReadWrite = 1'b1;
            MemAddress   = idx_b;
            MemDataIn    = din2_q;
         end
         default: ;
      endcase
   end

endmodule
